// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared types and constants for the button trigger controller
package trigger_pkg;

  localparam int         CNT_W   = 16;
  localparam logic [4:0] X5_ADDR = 5'd5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    ARMED     = 2'd2,
    WAIT_REL  = 2'd3
  } state_t;

  // Press counter stops at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/trigger_ctrl.sv
// rtl/trigger_ctrl.sv - debounced button trigger that holds x5 high until software clears it
module trigger_ctrl
  import trigger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_in,
  input  logic        RegWrite,
  input  logic [4:0]  rd,
  input  logic [31:0] WD3,
  output logic        trigger,
  output logic [7:0]  press_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_s;
  logic             w_ack;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [7:0]       r_press_count;
  logic [7:0]       w_press_count_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (w_btn_s)
  );

  // Software acknowledges by writing zero to x5.
  assign w_ack = RegWrite && (rd == X5_ADDR) && (WD3 == 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_press_count <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_press_count <= w_press_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_press_count_nxt = r_press_count;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = DEB_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      DEB_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt       = ARMED;
          w_press_count_nxt = sat_inc8(r_press_count);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ARMED: begin
        // The button level is irrelevant here; only the ack leaves this state.
        if (w_ack) begin
          w_state_nxt = WAIT_REL;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_REL: begin
        if (w_btn_s) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign trigger     = (r_state == ARMED);
  assign press_count = r_press_count;

endmodule

// File: tb/tb_trigger_ctrl.sv
// tb/tb_trigger_ctrl.sv - self-checking bench for trigger_ctrl with DEBOUNCE_CYCLES=4
module tb_trigger_ctrl;
  import trigger_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn_in;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic        trigger;
  logic [7:0]  press_count;

  int total = 0;
  int bad   = 0;

  trigger_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .RegWrite    (RegWrite),
    .rd          (rd),
    .WD3         (WD3),
    .trigger     (trigger),
    .press_count (press_count)
  );

  always #5 clk = ~clk;

  // Reference: the controller sees btn_in two edges late; a press is accepted after
  // N+1 consecutive high observations from rest, and rest is regained after N
  // consecutive low observations following the ack.
  bit m_h1, m_h2;
  int m_mode;   // 0 rest/pressing, 1 raised, 2 waiting for release
  int m_hi, m_lo, m_count;

  function automatic void model_reset();
    m_h1 = 0; m_h2 = 0; m_mode = 0; m_hi = 0; m_lo = 0; m_count = 0;
  endfunction

  function automatic void model_edge(bit b, bit ack_now);
    bit bs;
    bs = m_h2;
    if (m_mode == 0) begin
      m_hi = bs ? m_hi + 1 : 0;
      if (m_hi == N + 1) begin
        m_mode  = 1;
        m_count = (m_count < 255) ? m_count + 1 : 255;
      end
    end else if (m_mode == 1) begin
      if (ack_now) begin
        m_mode = 2;
        m_lo   = 0;
      end
    end else begin
      m_lo = bs ? 0 : m_lo + 1;
      if (m_lo == N) begin
        m_mode = 0;
        m_hi   = 0;
      end
    end
    m_h2 = m_h1;
    m_h1 = b;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge(btn_in, RegWrite && rd == 5'd5 && WD3 == 32'd0);
    @(negedge clk);
    check({name, "_trig"}, int'(trigger), (m_mode == 1) ? 1 : 0);
    check({name, "_count"}, int'(press_count), m_count);
  endtask

  task automatic set_ack(input bit on);
    RegWrite = on; rd = on ? 5'd5 : 5'd0; WD3 = 32'd0;
  endtask

  task automatic async_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_rst_trig"}, int'(trigger), 0);
    check({name, "_rst_count"}, int'(press_count), 0);
    check({name, "_rst_state"}, int'(dut.r_state), int'(IDLE));
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        btn;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        exp_trig;
    int          exp_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic b, input logic w, input logic [4:0] a,
                     input logic [31:0] d, input logic t, input int c);
    vec_t v;
    v.btn = b; v.rw = w; v.rd = a; v.wd = d; v.exp_trig = t; v.exp_cnt = c;
    tbl.push_back(v);
  endtask

  initial begin
    int edges;
    int highs;

    rst_n = 1'b0; btn_in = 1'b0; set_ack(0);
    model_reset();
    repeat (2) @(negedge clk);
    check("init_trig", int'(trigger), 0);
    check("init_count", int'(press_count), 0);
    check("init_state", int'(dut.r_state), int'(IDLE));
    rst_n = 1'b1;

    // Held press, non-clearing writes while raised, then the real clear.
    for (int i = 0; i < 6; i++) add(1, 0, 5'd0, 32'd0, 0, 0);
    add(1, 0, 5'd0, 32'd0, 1, 1);
    add(1, 1, 5'd5, 32'd1, 1, 1);
    add(1, 1, 5'd6, 32'd0, 1, 1);
    add(1, 0, 5'd5, 32'd0, 1, 1);
    add(1, 1, 5'd5, 32'd0, 0, 1);
    add(0, 1, 5'd5, 32'd0, 0, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 5'd0, 32'd0, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      btn_in = tbl[i].btn; RegWrite = tbl[i].rw; rd = tbl[i].rd; WD3 = tbl[i].wd;
      step("tbl");
      check($sformatf("tbl%0d_trig", i + 1), int'(trigger), int'(tbl[i].exp_trig));
      check($sformatf("tbl%0d_count", i + 1), int'(press_count), tbl[i].exp_cnt);
    end
    set_ack(0);

    // Short glitch must be rejected.
    highs = 0;
    btn_in = 1'b1;
    repeat (3) begin step("glitch"); highs += int'(trigger); end
    btn_in = 1'b0;
    repeat (8) begin step("glitch"); highs += int'(trigger); end
    check("glitch_highs", highs, 0);
    check("glitch_count", int'(press_count), 1);

    // Button held through the ack must not re-arm.
    async_reset("held");
    btn_in = 1'b1;
    edges = 0;
    while (!trigger && edges < 20) begin step("held_press"); edges++; end
    check("held_latency", edges, N + 3);
    set_ack(1);
    step("held_ack");
    check("held_ack_trig", int'(trigger), 0);
    set_ack(0);
    highs = 0;
    repeat (20) begin step("held_hold"); highs += int'(trigger); end
    check("held_no_rearm", highs, 0);
    btn_in = 1'b0;
    repeat (4) step("held_low");
    btn_in = 1'b1;
    edges = 0;
    while (!trigger && edges < 20) begin step("repress"); edges++; end
    check("repress_trig", int'(trigger), 1);
    check("repress_count", int'(press_count), 2);
    btn_in = 1'b0; set_ack(1);
    step("repress_ack");
    set_ack(0);
    repeat (8) step("repress_rel");

    // Asynchronous reset while raised, then a fresh debounce with the button still high.
    btn_in = 1'b1;
    edges = 0;
    while (!trigger && edges < 20) begin step("rst_press"); edges++; end
    check("rst_armed", int'(trigger), 1);
    async_reset("armed");
    edges = 0;
    while (!trigger && edges < 20) begin step("post_rst"); edges++; end
    check("post_rst_latency", edges, N + 3);
    check("post_rst_count", int'(press_count), 1);
    btn_in = 1'b0; set_ack(1);
    step("post_rst_ack");
    set_ack(0);
    repeat (8) step("post_rst_rel");

    // Counter saturation over 257 accepted presses.
    async_reset("sat");
    for (int p = 0; p < 257; p++) begin
      btn_in = 1'b1;
      repeat (N + 3) step("sat_press");
      set_ack(1);
      step("sat_ack");
      set_ack(0);
      btn_in = 1'b0;
      repeat (8) step("sat_rel");
      if (p == 254) check("sat_255", int'(press_count), 255);
    end
    check("sat_final", int'(press_count), 255);

    // Random button activity and register writes against the reference.
    async_reset("rand");
    btn_in = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_in = ~btn_in;
      RegWrite = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd5;
      WD3 = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
